// File: rtl/rf_pkg.sv
// Shared register-file constants and the dump engine state type.
// The register file and the writeback stage use these as well.
package rf_pkg;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int RF_N  = 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} dump_state_t;
endpackage

// File: rtl/rf_dump_outreg.sv
// Valid/data/index output register with load enable, drop on accept and a
// synchronous clear that overrides both.
module rf_dump_outreg #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          load,
    input  logic          drop,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_idx,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx
);
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_idx   <= in_idx;
        end else if (drop) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/rf_dump.sv
// Register-file read-out engine: walks the read port from the first index to
// N_REGS-1 and streams each value through a valid/ready output.
module rf_dump
    import rf_pkg::*;
#(
    parameter int N_REGS    = RF_N,
    parameter int AW        = RF_AW,
    parameter int DW        = RF_DW,
    parameter int SKIP_ZERO = 1
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] RDA,
    input  logic [DW-1:0] RD,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx
);
    if (N_REGS > (1 << AW) || N_REGS <= SKIP_ZERO) begin : g_param_check
        $error("rf_dump: N_REGS must be <= 2**AW and > SKIP_ZERO");
    end

    dump_state_t   state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          done_d;
    logic          load;
    logic          accept_last;
    logic          at_last;

    assign load        = (state_q == RUN) && (!out_valid || out_ready);
    assign accept_last = (state_q == DRAIN) && out_valid && out_ready;
    assign at_last     = (rd_ptr_q == AW'(N_REGS - 1));
    assign busy        = (state_q != IDLE);
    assign RDA         = rd_ptr_q;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            done     <= done_d;
        end
    end

    // abort overrides start and any handshake in the same cycle
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rd_ptr_d = (SKIP_ZERO != 0) ? AW'(1) : '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        if (at_last) state_d  = DRAIN;
                        else         rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (accept_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    rf_dump_outreg #(.AW(AW), .DW(DW)) u_outreg (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .clear    (abort),
        .load     (load),
        .drop     (accept_last),
        .in_data  (RD),
        .in_idx   (rd_ptr_q),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_idx  (out_idx)
    );
endmodule

// File: tb/tb_rf_dump.sv
// Self-checking bench for rf_dump: register-file model, expected-order
// scoreboard, backpressure, concurrent writes, abort and async reset.
module tb_rf_dump;
    import rf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, ready, sel;
    logic [31:0] regs [32];

    logic        busy_m, done_m, vld_m, busy_z, done_z, vld_z;
    logic [4:0]  rda_m, rda_z, idx_m, idx_z;
    logic [31:0] data_m, data_z;

    logic        c_valid, c_busy, c_done;
    logic [4:0]  c_idx, c_rda;
    logic [31:0] c_data;

    int n_cmp = 0;
    int n_bad = 0;

    rf_dump #(.N_REGS(32), .AW(5), .DW(32), .SKIP_ZERO(1)) dut (
        .CLK(clk), .reset_n(rst_n), .start(start && !sel), .abort(abort && !sel),
        .busy(busy_m), .done(done_m), .RDA(rda_m), .RD(regs[rda_m]),
        .out_valid(vld_m), .out_ready(ready), .out_data(data_m), .out_idx(idx_m)
    );

    rf_dump #(.N_REGS(32), .AW(5), .DW(32), .SKIP_ZERO(0)) dut_z (
        .CLK(clk), .reset_n(rst_n), .start(start && sel), .abort(abort && sel),
        .busy(busy_z), .done(done_z), .RDA(rda_z), .RD(regs[rda_z]),
        .out_valid(vld_z), .out_ready(ready), .out_data(data_z), .out_idx(idx_z)
    );

    assign c_valid = sel ? vld_z  : vld_m;
    assign c_busy  = sel ? busy_z : busy_m;
    assign c_done  = sel ? done_z : done_m;
    assign c_idx   = sel ? idx_z  : idx_m;
    assign c_rda   = sel ? rda_z  : rda_m;
    assign c_data  = sel ? data_z : data_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int n);
        if (mode == 1) return 1'b1;
        if (mode == 2) return (n % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected stream: indices first..31 in order, each carrying the register
    // value at capture time (writes to not-yet-captured indices show up).
    task automatic run_dump(input bit z, input int mode, input int wr_at, input string tag);
        int          first, cnt, n, got, done_at, e;
        bit          stall, wrote;
        logic [31:0] sd;
        logic [4:0]  si;
        logic [31:0] shadow [32];
        int          q[$];
        sel   = z;
        first = z ? 0 : 1;
        cnt   = 32 - first;
        for (int i = 0; i < 32; i++) shadow[i] = regs[i];
        for (int i = first; i < 32; i++) q.push_back(i);
        start = 1'b1;
        ready = pick_ready(mode, 0);
        cycle();
        start = 1'b0;
        n = 0;
        chk({tag, ".rda_first"}, c_rda, first);
        chk({tag, ".busy_run"}, c_busy, 1);
        done_at = -1; stall = 0; got = 0; wrote = 0; sd = '0; si = '0;
        while (done_at < 0 && n < 400) begin
            if (stall) begin
                chk({tag, ".stall_valid"}, c_valid, 1);
                chk({tag, ".stall_data"}, c_data, sd);
                chk({tag, ".stall_idx"}, c_idx, si);
            end
            if (mode == 1 && n == 1) chk({tag, ".first_latency"}, c_valid, 1);
            ready = pick_ready(mode, n);
            if (wr_at >= 0 && !wrote && c_valid && int'(c_idx) == wr_at) begin
                wrote = 1;
                regs[20] = 32'hDEAD_BEEF;
                regs[5]  = 32'h0000_1234;
                if (20 > int'(c_idx)) shadow[20] = 32'hDEAD_BEEF;
                if (5 > int'(c_idx))  shadow[5]  = 32'h0000_1234;
            end
            if (c_valid && ready) begin
                if (q.size() == 0) begin
                    chk({tag, ".extra_word"}, c_idx, 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk({tag, ".idx"}, c_idx, e);
                    chk({tag, ".data"}, c_data, shadow[e]);
                    got++;
                end
            end
            stall = c_valid && !ready;
            sd = c_data;
            si = c_idx;
            cycle();
            n++;
            if (c_done) done_at = n;
        end
        chk({tag, ".done_seen"}, done_at >= 0, 1);
        if (mode == 1) chk({tag, ".done_cycle"}, done_at, cnt + 1);
        chk({tag, ".word_count"}, got, cnt);
        chk({tag, ".busy_at_done"}, c_busy, 0);
        chk({tag, ".valid_at_done"}, c_valid, 0);
        cycle();
        chk({tag, ".done_pulse"}, c_done, 0);
        sel = 1'b0;
    endtask

    initial begin
        sel = 0; start = 0; abort = 0; ready = 0; rst_n = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 + i;
        regs[0] = '0;
        #12;
        chk("rst.valid", vld_m, 0);
        chk("rst.data", data_m, 0);
        chk("rst.idx", idx_m, 0);
        chk("rst.busy", busy_m, 0);
        chk("rst.done", done_m, 0);
        chk("rst.rda", rda_m, 0);
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk("idle.busy", busy_m, 0);

        run_dump(0, 1, -1, "full");
        run_dump(0, 2, -1, "bp");
        run_dump(1, 1, -1, "skip0");
        run_dump(0, 1, 10, "wr");
        chk("wr.reg20_new", regs[20], 32'hDEAD_BEEF);

        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            run_dump(k == 2, 0, -1, "rand");
        end

        // abort while idx 12 is pending with out_ready low
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'hA500_0000 + i;
        sel = 0; start = 1; ready = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 100 && !(vld_m && idx_m == 5'd12); i++) cycle();
        chk("abort.reach12", idx_m, 12);
        ready = 0; abort = 1;
        cycle();
        abort = 0;
        chk("abort.valid", vld_m, 0);
        chk("abort.busy", busy_m, 0);
        chk("abort.done", done_m, 0);
        chk("abort.rda", rda_m, 0);
        cycle();
        chk("abort.no_done", done_m, 0);
        run_dump(0, 1, -1, "post_abort");

        // asynchronous reset in the middle of a dump
        start = 1; ready = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 100 && !(vld_m && idx_m == 5'd8); i++) cycle();
        #2 rst_n = 0;
        #1;
        chk("arst.valid", vld_m, 0);
        chk("arst.data", data_m, 0);
        chk("arst.idx", idx_m, 0);
        chk("arst.busy", busy_m, 0);
        chk("arst.rda", rda_m, 0);
        chk("arst.done", done_m, 0);
        @(negedge clk);
        rst_n = 1;
        cycle();
        run_dump(0, 1, -1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_dump.md
# rf_dump

Sequential read-out engine for the 32×32 register file: on a start pulse it walks the register file's read port from the first index to the last and streams each register value out through a valid/ready interface. Used for context save, debug dump and register-file checking. It sits beside the writeback path, owns one register-file read address port, and is the reading counterpart of the register-file write port.

## Interface
- N_REGS, 32: number of registers walked.
- AW, 5: register address width.
- DW, 32: data width.
- SKIP_ZERO, 1: 1 starts the walk at index 1, because x0 is hard-wired to 0; 0 starts at index 0.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; takes priority over every other input.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last word is accepted.
- RDA  out  AW  read address to the register file; equals rd_ptr.
- RD  in  DW  combinational read data from the register file for RDA.
- out_valid  out  1  out_data and out_idx are valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DW  register value.
- out_idx  out  AW  index of the register in out_data.

## Operation
- Registers: state, rd_ptr[AW-1:0], out_valid, out_data, out_idx, done.
- Reset values, all outputs and registers: state=IDLE, rd_ptr=0, out_valid=0, out_data=0, out_idx=0, done=0, busy=0, RDA=0.
- load = (state==RUN) && (!out_valid || out_ready).
- IDLE:
  - On start: rd_ptr ← SKIP_ZERO ? 1 : 0 and go to RUN.
  - Otherwise hold all registers.
- RUN, when load is true:
  - out_data ← RD, out_idx ← rd_ptr, out_valid ← 1.
  - If rd_ptr == N_REGS-1, go to DRAIN and hold rd_ptr (no wrap); otherwise rd_ptr ← rd_ptr+1.
- RUN, when load is false: hold everything. Backpressure stalls the walk, and out_data and out_idx stay stable while out_valid=1 and out_ready=0.
- DRAIN:
  - On out_valid && out_ready: out_valid ← 0, done ← 1 for one cycle, go to IDLE.
- Handshake rules:
  - A word transfers on any edge where out_valid && out_ready.
  - out_valid never drops without a transfer, except on abort or reset.
- Concurrent register-file writes: each word is the value of RD at its capture edge. A write to a register already captured is not reflected; a write to a register not yet captured is.
- start while busy: ignored. start in the same cycle as done: accepted, because the block is already in IDLE.
- abort in any state: next edge gives state=IDLE, out_valid=0, done=0, rd_ptr=0. No done pulse. abort has priority over start and over a handshake in the same cycle.
- reset_n low mid-dump: immediate return to reset values. No partial done.
- Word count per dump: N_REGS − SKIP_ZERO, i.e. 31 with defaults.
- Width rules:
  - rd_ptr increment is AW bits, and the terminal compare against N_REGS-1 prevents wrap.
  - N_REGS must be ≤ 2^AW and > SKIP_ZERO; this is checked by an elaboration assertion.

## Timing
- Edge e0 samples start. After e0, RDA = first index.
- After e1: out_valid=1 with register[first]. First-word latency is 2 edges from start.
- With out_ready held high: one word per cycle and no bubbles; the last word is valid after edge e(N_REGS−SKIP_ZERO).
- The edge that accepts the last word clears out_valid and busy and raises done for exactly one cycle.
- Full dump with defaults and no stalls: 32 cycles from start to done.
- RD is a same-cycle combinational path from RDA. rf_dump adds no combinational path from out_ready to RDA beyond the registered rd_ptr.

## Structure
- Shared package rf_pkg holds:
  - RF_AW=5, RF_DW=32, RF_N=32.
  - typedef dump_state_t {IDLE, RUN, DRAIN}.
  - These are also used by the register file and the writeback stage.
- Single module; no sub-module required.
- The output register stage (valid/data/idx with load enable) can be factored as rf_dump_outreg if it is reused elsewhere.

## Test plan
- Preload reg[i]=0xA500_0000+i, pulse start, hold out_ready=1 → 31 words with out_idx 1..31 and matching data on consecutive cycles, done 32 cycles after start, busy low after done.
- Same preload with out_ready toggling 1,0,0,1,… → no word lost or duplicated, out_data stable during stalls, order 1..31.
- SKIP_ZERO=0 → 32 words, first word idx 0 with data 0.
- Write reg[20]=0xDEAD_BEEF while reg[10] is on the output, and write reg[5]=0x1234 in the same cycle → dump shows reg[20]=0xDEAD_BEEF and reg[5] with its old value.
- abort while idx 12 is pending and out_ready=0 → out_valid=0 next cycle, no done; a new start then produces a full 31-word dump.
- reset_n pulled low asynchronously mid-dump → outputs zero immediately; after release, start yields a normal dump.
